// File: rtl/axis_video_packer.sv
// Pixel-lane to AXI4-Stream video packer: truncates components, tags SOF/EOL from
// write-side geometry counters and buffers beats against TREADY backpressure.
module axis_video_packer #(
  parameter int LANES       = 6,
  parameter int COMP_IN_W   = 10,
  parameter int COMP_OUT_W  = 8,
  parameter int LINE_BEATS  = 3840,
  parameter int FRAME_LINES = 2610,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [LANES*COMP_IN_W-1:0]        pix_data_i,
  input  logic [LANES-1:0]                  pix_valid_i,
  input  logic                              frame_start_i,
  input  logic                              clear_overflow_i,
  output logic [LANES*COMP_OUT_W-1:0]       m_axis_video_TDATA,
  output logic [LANES*COMP_OUT_W/8-1:0]     m_axis_video_TKEEP,
  output logic [LANES*COMP_OUT_W/8-1:0]     m_axis_video_TSTRB,
  output logic                              m_axis_video_TLAST,
  output logic                              m_axis_video_TUSER,
  output logic                              m_axis_video_TVALID,
  input  logic                              m_axis_video_TREADY,
  output logic                              m_axis_video_TDEST,
  output logic                              m_axis_video_TID,
  output logic                              overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);

  localparam int DW  = LANES * COMP_OUT_W;
  localparam int BPL = COMP_OUT_W / 8;
  localparam int KW  = LANES * BPL;
  localparam int EW  = DW + KW + 2;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(LINE_BEATS + 1);
  localparam int LCW = $clog2(FRAME_LINES + 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(LINE_BEATS - 1);
  localparam logic [LCW-1:0] LINE_LAST = LCW'(FRAME_LINES - 1);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(FIFO_DEPTH);

  logic [DW-1:0]  wr_data;
  logic [KW-1:0]  wr_keep;
  logic           wr_beat, sof, eol;
  logic [EW-1:0]  wr_entry;

  assign wr_beat = |pix_valid_i;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wr_data[i*COMP_OUT_W +: COMP_OUT_W] = pix_data_i[i*COMP_IN_W + COMP_IN_W - 1 -: COMP_OUT_W];
    assign wr_keep[i*BPL +: BPL]               = {BPL{pix_valid_i[i]}};
  end

  // Truncated LSBs are intentionally discarded.
  logic unused_pix;
  assign unused_pix = ^pix_data_i;

  logic [BCW-1:0] beat_q, beat_d;
  logic [LCW-1:0] line_q, line_d;

  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    sof    = 1'b0;
    eol    = 1'b0;
    if (frame_start_i && wr_beat) begin
      sof = 1'b1;
      if (LINE_BEATS == 1) begin
        eol    = 1'b1;
        beat_d = '0;
        line_d = (FRAME_LINES == 1) ? '0 : LCW'(1);
      end else begin
        beat_d = BCW'(1);
        line_d = '0;
      end
    end else if (frame_start_i) begin
      beat_d = '0;
      line_d = '0;
    end else if (wr_beat) begin
      sof = (beat_q == '0) && (line_q == '0);
      eol = (beat_q == BEAT_LAST);
      if (beat_q == BEAT_LAST) begin
        beat_d = '0;
        line_d = (line_q == LINE_LAST) ? '0 : line_q + LCW'(1);
      end else begin
        beat_d = beat_q + BCW'(1);
      end
    end
  end

  assign wr_entry = {sof, eol, wr_keep, wr_data};

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, mem_cnt;
  logic [EW-1:0] out_q, out_d;
  logic          tvalid_q, tvalid_d, ovf_q, ovf_d;
  logic          rd, wr_ok, drop, load, mem_empty, mem_wr;

  // The output register is the FIFO head; the memory holds everything behind it.
  assign rd        = tvalid_q && m_axis_video_TREADY;
  assign wr_ok     = wr_beat && ((level_q != LVL_FULL) || rd);
  assign drop      = wr_beat && !wr_ok;
  assign mem_cnt   = level_q - LW'(tvalid_q);
  assign mem_empty = (mem_cnt == '0);
  assign load      = !tvalid_q || rd;
  assign mem_wr    = wr_ok && !(load && mem_empty);

  always_comb begin
    out_d    = out_q;
    tvalid_d = tvalid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = mem_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d  = level_q + LW'(wr_ok) - LW'(rd);
    ovf_d    = drop ? 1'b1 : (clear_overflow_i ? 1'b0 : ovf_q);
    if (load) begin
      if (!mem_empty) begin
        out_d    = mem_q[rd_ptr_q];
        tvalid_d = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else if (wr_ok) begin
        out_d    = wr_entry;
        tvalid_d = 1'b1;
      end else begin
        tvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_q   <= '0;
      line_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      out_q    <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      line_q   <= line_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      out_q    <= out_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign m_axis_video_TDATA  = out_q[DW-1:0];
  assign m_axis_video_TKEEP  = out_q[DW +: KW];
  assign m_axis_video_TSTRB  = out_q[DW +: KW];
  assign m_axis_video_TLAST  = out_q[DW+KW];
  assign m_axis_video_TUSER  = out_q[DW+KW+1];
  assign m_axis_video_TVALID = tvalid_q;
  assign m_axis_video_TDEST  = 1'b1;
  assign m_axis_video_TID    = 1'b1;
  assign overflow_o          = ovf_q;
  assign fifo_level_o        = level_q;

endmodule

// File: tb/tb_axis_video_packer.sv
// Directed bench for axis_video_packer with a short 4x2 frame geometry.
module tb_axis_video_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [59:0] pix_data;
  logic [5:0]  pix_valid;
  logic        frame_start, clear_ovf, tready;
  logic [47:0] tdata;
  logic [5:0]  tkeep, tstrb;
  logic        tlast, tuser, tvalid, tdest, tid, overflow;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  axis_video_packer #(
    .LANES(6), .COMP_IN_W(10), .COMP_OUT_W(8),
    .LINE_BEATS(4), .FRAME_LINES(2), .FIFO_DEPTH(16)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .pix_data_i(pix_data), .pix_valid_i(pix_valid),
    .frame_start_i(frame_start), .clear_overflow_i(clear_ovf),
    .m_axis_video_TDATA(tdata), .m_axis_video_TKEEP(tkeep),
    .m_axis_video_TSTRB(tstrb), .m_axis_video_TLAST(tlast),
    .m_axis_video_TUSER(tuser), .m_axis_video_TVALID(tvalid),
    .m_axis_video_TREADY(tready), .m_axis_video_TDEST(tdest),
    .m_axis_video_TID(tid), .overflow_o(overflow), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  // Lane i carries (n+i) in its 8 MSBs with junk LSBs that must be truncated.
  function automatic logic [59:0] mk(input int n);
    logic [59:0] v;
    for (int i = 0; i < 6; i++) v[i*10 +: 10] = {8'(n + i), 2'b01};
    return v;
  endfunction

  function automatic logic [47:0] expd(input int n);
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[i*8 +: 8] = 8'(n + i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fs_v [6]  = '{0, 0, 1, 0, 0, 0};
  int usr_v [6] = '{1, 0, 1, 0, 0, 0};
  int lst_v [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    reset_n = 1'b0; pix_data = '0; pix_valid = '0;
    frame_start = 1'b0; clear_ovf = 1'b0; tready = 1'b1;

    #12;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("tdest_const", tdest, 1);
    chk("tid_const", tid, 1);
    #5 reset_n = 1'b1;
    tick();

    // Two full lines at full throughput.
    pix_valid = 6'h3F;
    pix_data  = mk(0);
    chk("tvalid_before_first_edge", tvalid, 0);
    for (int k = 0; k < 8; k++) begin
      pix_data = mk(k);
      tick();
      chk("stream_tvalid", tvalid, 1);
      chk("stream_tdata", tdata, expd(k));
      chk("stream_tuser", tuser, (k == 0));
      chk("stream_tlast", tlast, (k == 3 || k == 7));
      chk("stream_level", level, 1);
    end
    pix_valid = '0;
    tick();
    chk("idle_tvalid", tvalid, 0);
    chk("idle_level", level, 0);

    // Truncation and partial byte enables.
    pix_data  = {10'h2AB, 10'h100, 10'h0FF, 10'h001, 10'h200, 10'h3FF};
    pix_valid = 6'b000011;
    tick();
    chk("trunc_tdata", tdata, 48'hAA403F0080FF);
    chk("trunc_tkeep", tkeep, 6'b000011);
    chk("trunc_tstrb", tstrb, 6'b000011);
    chk("trunc_tuser", tuser, 1);
    pix_valid   = '0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("resync_tvalid", tvalid, 0);
    chk("resync_level", level, 0);

    // 20-cycle stall: 16 stored, 4 dropped.
    tready    = 1'b0;
    pix_valid = 6'h3F;
    for (int j = 0; j < 20; j++) begin
      pix_data = mk(100 + j);
      tick();
      chk("stall_level", level, (j + 1 > 16) ? 16 : j + 1);
      chk("stall_tdata_hold", tdata, expd(100));
      chk("stall_overflow", overflow, (j >= 16));
    end
    pix_valid = '0;
    tready    = 1'b1;
    for (int d = 0; d < 16; d++) begin
      chk("drain_tvalid", tvalid, 1);
      chk("drain_tdata", tdata, expd(100 + d));
      chk("drain_tuser", tuser, (d % 8 == 0));
      chk("drain_tlast", tlast, (d % 4 == 3));
      chk("drain_level", level, 16 - d);
      tick();
    end
    chk("drained_tvalid", tvalid, 0);
    chk("drained_level", level, 0);
    chk("drained_overflow_sticky", overflow, 1);
    pix_valid = 6'h3F;
    for (int k = 0; k < 4; k++) begin
      pix_data = mk(200 + k);
      tick();
      chk("post_drop_tdata", tdata, expd(200 + k));
      chk("post_drop_tlast", tlast, (k == 3));
      chk("post_drop_tuser", tuser, 0);
    end

    // Mid-line frame_start together with a beat.
    for (int k = 0; k < 6; k++) begin
      pix_data    = mk(30 + k);
      frame_start = (fs_v[k] != 0);
      tick();
      chk("fs_tdata", tdata, expd(30 + k));
      chk("fs_tuser", tuser, usr_v[k]);
      chk("fs_tlast", tlast, lst_v[k]);
    end
    frame_start = 1'b0;
    pix_valid   = '0;
    tick();
    chk("fs_drained_level", level, 0);

    // Full FIFO with simultaneous read and write.
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("clear_overflow", overflow, 0);
    tready    = 1'b0;
    pix_valid = 6'h3F;
    for (int j = 0; j < 16; j++) begin
      pix_data = mk(50 + j);
      tick();
      chk("fill_level", level, j + 1);
    end
    chk("fill_tdata", tdata, expd(50));
    chk("fill_overflow", overflow, 0);
    tready   = 1'b1;
    pix_data = mk(66);
    tick();
    chk("full_rw_level", level, 16);
    chk("full_rw_overflow", overflow, 0);
    chk("full_rw_tdata", tdata, expd(51));
    tready    = 1'b0;
    pix_data  = mk(67);
    clear_ovf = 1'b1;
    tick();
    chk("set_beats_clear", overflow, 1);
    chk("set_beats_clear_level", level, 16);
    pix_valid = '0;
    tick();
    clear_ovf = 1'b0;
    chk("clear_after_drop", overflow, 0);

    // Reset mid-stream with 5 beats buffered.
    tready = 1'b1;
    repeat (11) tick();
    chk("prereset_level", level, 5);
    chk("prereset_tvalid", tvalid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tvalid", tvalid, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_tdata", tdata, 0);
    chk("async_rst_tuser", tuser, 0);
    tick();
    reset_n   = 1'b1;
    pix_valid = 6'h3F;
    pix_data  = mk(7);
    tick();
    chk("postrst_tvalid", tvalid, 1);
    chk("postrst_tuser", tuser, 1);
    chk("postrst_tdata", tdata, expd(7));
    chk("postrst_level", level, 1);
    pix_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
